// File: rtl/avg_pkg.sv
// avg_pkg: shared FSM encoding and width helpers for the stream serializer
package avg_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int sum_width(input int word_w, input int nwords);
    return word_w + clog2(nwords);
  endfunction
endpackage

// File: rtl/word_accumulator.sv
// word_accumulator: running sum of emitted words, clear has priority over add
module word_accumulator #(
  parameter int WORD_W = 8,
  parameter int SUM_W  = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [WORD_W-1:0] din,
  output logic [SUM_W-1:0]  acc
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) acc <= '0;
    else acc <= clr ? '0 : en ? acc + SUM_W'(din) : acc;
endmodule

// File: rtl/stream_word_serializer.sv
// stream_word_serializer: loads a wide stream word, emits it word by word, publishes per-stream sum/avg
module stream_word_serializer
  import avg_pkg::*;
#(
  parameter int STREAM_W  = 64,
  parameter int WORD_W    = 8,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 8,
  localparam int NWORDS   = STREAM_W / WORD_W,
  localparam int IDX_W    = clog2(NWORDS),
  localparam int SUM_W    = sum_width(WORD_W, NWORDS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STREAM_W-1:0] data_stream,
  input  logic                load_valid,
  output logic                load_ready,
  output logic [WORD_W-1:0]   q,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                last,
  output logic [IDX_W-1:0]    idx,
  output logic [CNT_W-1:0]    count,
  output logic [SUM_W-1:0]    sum,
  output logic [WORD_W-1:0]   avg,
  output logic                sum_valid
);
  if (STREAM_W % WORD_W != 0 || NWORDS < 2 || (NWORDS & (NWORDS - 1)) != 0) begin : g_bad_params
    $error("stream_word_serializer: STREAM_W/WORD_W must be a power of two >= 2");
  end
  state_t state, state_nx;
  logic [STREAM_W-1:0] shreg;
  logic [SUM_W-1:0] acc, sum_nx;
  logic load_fire, out_fire, last_fire;
  assign out_valid  = state == ST_SHIFT;
  assign q          = MSB_FIRST != 0 ? shreg[STREAM_W-1 -: WORD_W] : shreg[WORD_W-1:0];
  assign last       = out_valid && idx == IDX_W'(NWORDS - 1);
  assign load_ready = state == ST_IDLE || (last && out_ready);
  assign load_fire  = load_valid && load_ready;
  assign out_fire   = out_valid && out_ready;
  assign last_fire  = out_fire && last;
  // the last word is still in flight, so fold it into the published sum here
  assign sum_nx     = acc + SUM_W'(q);
  always_comb begin
    state_nx = state;
    state_nx = load_fire ? ST_SHIFT : last_fire ? ST_IDLE : state;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      idx       <= '0;
      count     <= '0;
      sum       <= '0;
      avg       <= '0;
      sum_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      shreg     <= load_fire ? data_stream :
                   out_fire  ? (MSB_FIRST != 0 ? shreg << WORD_W : shreg >> WORD_W) : shreg;
      idx       <= load_fire ? '0 : out_fire ? idx + IDX_W'(1) : idx;
      count     <= out_fire ? count + CNT_W'(1) : count;
      sum_valid <= last_fire;
      if (last_fire) begin
        sum <= sum_nx;
        avg <= sum_nx[SUM_W-1:IDX_W];
      end
    end
  word_accumulator #(.WORD_W(WORD_W), .SUM_W(SUM_W)) u_acc (
    .clk (clk),
    .rst (rst),
    .clr (load_fire),
    .en  (out_fire),
    .din (q),
    .acc (acc)
  );
endmodule

// File: tb/tb_stream_word_serializer.sv
// tb_stream_word_serializer: directed vectors over default, LSB-first and 4-bit-counter instances
module tb_stream_word_serializer;
  logic clk = 1'b0, rst = 1'b0, load_valid = 1'b0, out_ready = 1'b0;
  logic [63:0] data_stream = '0;
  logic lr0, ov0, last0, sv0, lr1, ov1, last1, sv1, lr2, ov2, last2, sv2;
  logic [7:0] q0, q1, q2, cnt0, cnt1, avg0, avg1, avg2;
  logic [3:0] cnt2;
  logic [2:0] idx0, idx1, idx2;
  logic [10:0] sum0, sum1, sum2;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  stream_word_serializer d0 (
    .clk(clk), .rst(rst), .data_stream(data_stream), .load_valid(load_valid), .load_ready(lr0),
    .q(q0), .out_valid(ov0), .out_ready(out_ready), .last(last0), .idx(idx0), .count(cnt0),
    .sum(sum0), .avg(avg0), .sum_valid(sv0));
  stream_word_serializer #(.MSB_FIRST(0)) d1 (
    .clk(clk), .rst(rst), .data_stream(data_stream), .load_valid(load_valid), .load_ready(lr1),
    .q(q1), .out_valid(ov1), .out_ready(out_ready), .last(last1), .idx(idx1), .count(cnt1),
    .sum(sum1), .avg(avg1), .sum_valid(sv1));
  stream_word_serializer #(.CNT_W(4)) d2 (
    .clk(clk), .rst(rst), .data_stream(data_stream), .load_valid(load_valid), .load_ready(lr2),
    .q(q2), .out_valid(ov2), .out_ready(out_ready), .last(last2), .idx(idx2), .count(cnt2),
    .sum(sum2), .avg(avg2), .sum_valid(sv2));
  typedef struct {
    logic lv, ordy;
    logic [63:0] data;
    logic ov, last, lr, sv;
    logic [7:0] qa, qb;
    logic [2:0] ix;
    logic [7:0] cn;
    logic [10:0] sm;
    logic [7:0] av;
  } vec_t;
  function automatic vec_t mk(input logic lv, ordy, input logic [63:0] d, input logic ov, last, lr, sv,
                              input logic [7:0] qa, qb, input logic [2:0] ix, input logic [7:0] cn,
                              input logic [10:0] sm, input logic [7:0] av);
    vec_t v;
    v.lv = lv; v.ordy = ordy; v.data = d; v.ov = ov; v.last = last; v.lr = lr; v.sv = sv;
    v.qa = qa; v.qb = qb; v.ix = ix; v.cn = cn; v.sm = sm; v.av = av;
    return v;
  endfunction
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  localparam logic [63:0] A = 64'h0102030405060708;
  localparam logic [63:0] F = 64'hFFFFFFFFFFFFFFFF;
  localparam logic [63:0] B = 64'h1010101010101010;
  vec_t v [21];
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    int pulses;
    logic [10:0] got_sum;
    logic [7:0] got_avg;
    v[0]  = mk(1, 1, A,   1, 0, 0, 0, 8'h01, 8'h08, 0, 0, 0, 0);
    v[1]  = mk(0, 1, 0,   1, 0, 0, 0, 8'h02, 8'h07, 1, 1, 0, 0);
    v[2]  = mk(0, 1, 0,   1, 0, 0, 0, 8'h03, 8'h06, 2, 2, 0, 0);
    v[3]  = mk(0, 0, 0,   1, 0, 0, 0, 8'h03, 8'h06, 2, 2, 0, 0);
    v[4]  = mk(0, 0, 0,   1, 0, 0, 0, 8'h03, 8'h06, 2, 2, 0, 0);
    v[5]  = mk(0, 0, 0,   1, 0, 0, 0, 8'h03, 8'h06, 2, 2, 0, 0);
    v[6]  = mk(0, 1, 0,   1, 0, 0, 0, 8'h04, 8'h05, 3, 3, 0, 0);
    v[7]  = mk(0, 1, 0,   1, 0, 0, 0, 8'h05, 8'h04, 4, 4, 0, 0);
    v[8]  = mk(0, 1, 0,   1, 0, 0, 0, 8'h06, 8'h03, 5, 5, 0, 0);
    v[9]  = mk(0, 1, 0,   1, 0, 0, 0, 8'h07, 8'h02, 6, 6, 0, 0);
    v[10] = mk(0, 1, 0,   1, 1, 1, 0, 8'h08, 8'h01, 7, 7, 0, 0);
    v[11] = mk(1, 1, F,   1, 0, 0, 1, 8'hFF, 8'hFF, 0, 8, 11'h024, 8'h04);
    v[12] = mk(0, 1, 0,   1, 0, 0, 0, 8'hFF, 8'hFF, 1, 9, 11'h024, 8'h04);
    v[13] = mk(1, 1, {4{16'h5555}}, 1, 0, 0, 0, 8'hFF, 8'hFF, 2, 10, 11'h024, 8'h04);
    v[14] = mk(0, 1, 0,   1, 0, 0, 0, 8'hFF, 8'hFF, 3, 11, 11'h024, 8'h04);
    v[15] = mk(0, 1, 0,   1, 0, 0, 0, 8'hFF, 8'hFF, 4, 12, 11'h024, 8'h04);
    v[16] = mk(0, 1, 0,   1, 0, 0, 0, 8'hFF, 8'hFF, 5, 13, 11'h024, 8'h04);
    v[17] = mk(0, 1, 0,   1, 0, 0, 0, 8'hFF, 8'hFF, 6, 14, 11'h024, 8'h04);
    v[18] = mk(0, 1, 0,   1, 1, 1, 0, 8'hFF, 8'hFF, 7, 15, 11'h024, 8'h04);
    v[19] = mk(0, 1, 0,   0, 0, 1, 1, 8'h00, 8'h00, 0, 16, 11'h7F8, 8'hFF);
    v[20] = mk(0, 0, 0,   0, 0, 1, 0, 8'h00, 8'h00, 0, 16, 11'h7F8, 8'hFF);
    repeat (2) @(posedge clk);
    #1;
    chk("rst ov", ov0, 0);
    chk("rst q", q0, 0);
    chk("rst idx", idx0, 0);
    chk("rst count", cnt0, 0);
    chk("rst sum", sum0, 0);
    chk("rst avg", avg0, 0);
    chk("rst sv", sv0, 0);
    chk("rst lr", lr0, 1);
    rst = 1'b1;
    for (int i = 0; i < 21; i++) begin
      load_valid = v[i].lv;
      out_ready = v[i].ordy;
      data_stream = v[i].data;
      @(posedge clk);
      #1;
      chk($sformatf("r%0d ov", i), ov0, v[i].ov);
      chk($sformatf("r%0d last", i), last0, v[i].last);
      chk($sformatf("r%0d lr", i), lr0, v[i].lr);
      chk($sformatf("r%0d sv", i), sv0, v[i].sv);
      chk($sformatf("r%0d q", i), q0, v[i].qa);
      chk($sformatf("r%0d idx", i), idx0, v[i].ix);
      chk($sformatf("r%0d count", i), cnt0, v[i].cn);
      chk($sformatf("r%0d sum", i), sum0, v[i].sm);
      chk($sformatf("r%0d avg", i), avg0, v[i].av);
      chk($sformatf("r%0d lsb q", i), q1, v[i].qb);
      chk($sformatf("r%0d lsb last", i), last1, v[i].last);
      chk($sformatf("r%0d lsb sum", i), sum1, v[i].sm);
      chk($sformatf("r%0d lsb avg", i), avg1, v[i].av);
      chk($sformatf("r%0d cnt4", i), cnt2, v[i].cn[3:0]);
      chk($sformatf("r%0d cnt4 sum", i), sum2, v[i].sm);
    end
    load_valid = 1'b1;
    data_stream = A;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    data_stream = '0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("abort q", q0, 8'h04);
    chk("abort count", cnt0, 8'd19);
    #3;
    rst = 1'b0;
    #1;
    chk("async ov", ov0, 0);
    chk("async q", q0, 0);
    chk("async idx", idx0, 0);
    chk("async count", cnt0, 0);
    chk("async sum", sum0, 0);
    chk("async avg", avg0, 0);
    chk("async sv", sv0, 0);
    chk("async lr", lr0, 1);
    chk("async cnt4", cnt2, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    load_valid = 1'b1;
    data_stream = B;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    pulses = 0;
    got_sum = '0;
    got_avg = '0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (sv0) begin
        pulses++;
        got_sum = sum0;
        got_avg = avg0;
      end
    end
    chk("post-abort pulses", pulses, 1);
    chk("post-abort sum", got_sum, 11'h080);
    chk("post-abort avg", got_avg, 8'h10);
    chk("post-abort count", cnt0, 8'd8);
    chk("post-abort ov", ov0, 0);
    chk("post-abort lsb sum", sum1, 11'h080);
    chk("post-abort cnt4", cnt2, 4'd8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
